// File: rtl/ball_state_bank.sv
// Double-buffered ball/cue position store.
// Software fills the shadow bank and requests a commit. The whole shadow bank
// is copied into the active bank at the next frame boundary, so the renderer
// never sees a half-updated table. The renderer reads the active bank through
// a registered port with one cycle of latency.
module ball_state_bank #(
    parameter int NUM_BALLS = 17,
    parameter int IDX_W     = 5,
    parameter int X_W       = 10,
    parameter int Y_W       = 10,
    parameter int CNT_W     = 16
) (
    input  logic             clk_clk,
    input  logic             reset_reset,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_index,
    input  logic [X_W-1:0]   wr_x,
    input  logic [Y_W-1:0]   wr_y,
    input  logic             wr_vis,
    input  logic             commit,
    input  logic             frame_start,
    input  logic             err_clr,
    input  logic             rd_en,
    input  logic [IDX_W-1:0] rd_index,
    output logic [X_W-1:0]   rd_x,
    output logic [Y_W-1:0]   rd_y,
    output logic             rd_vis,
    output logic             rd_valid,
    output logic             commit_pending,
    output logic             swap_done,
    output logic [CNT_W-1:0] frame_count,
    output logic             wr_err
);

    // One extra bit so the limit itself is representable even when
    // NUM_BALLS equals 2**IDX_W.
    localparam logic [IDX_W:0] SLOT_LIMIT = (IDX_W+1)'(NUM_BALLS);

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        PENDING = 1'b1
    } state_t;

    state_t state_reg;

    // Both banks live in flops: they must clear on reset and the swap
    // copies every slot in the same cycle.
    logic [X_W-1:0] shadow_x [NUM_BALLS];
    logic [Y_W-1:0] shadow_y [NUM_BALLS];
    logic           shadow_vis [NUM_BALLS];
    logic [X_W-1:0] active_x [NUM_BALLS];
    logic [Y_W-1:0] active_y [NUM_BALLS];
    logic           active_vis [NUM_BALLS];

    logic wr_in_range;
    logic rd_in_range;
    logic wr_accept;
    logic wr_reject;
    logic swap;

    assign wr_in_range = {1'b0, wr_index} < SLOT_LIMIT;
    assign rd_in_range = {1'b0, rd_index} < SLOT_LIMIT;
    // The shadow bank is frozen while a commit waits for its frame boundary.
    assign wr_accept   = wr_en && (state_reg == IDLE) && wr_in_range;
    assign wr_reject   = wr_en && !wr_accept;
    assign swap        = (state_reg == PENDING) && frame_start;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_BALLS; gi++) begin : g_slot
            // Per-slot shadow write and shadow-to-active copy on the swap edge.
            always_ff @(posedge clk_clk or posedge reset_reset) begin
                if (reset_reset) begin
                    shadow_x[gi]   <= '0;
                    shadow_y[gi]   <= '0;
                    shadow_vis[gi] <= 1'b0;
                    active_x[gi]   <= '0;
                    active_y[gi]   <= '0;
                    active_vis[gi] <= 1'b0;
                end else begin
                    if (wr_accept && (wr_index == IDX_W'(gi))) begin
                        shadow_x[gi]   <= wr_x;
                        shadow_y[gi]   <= wr_y;
                        shadow_vis[gi] <= wr_vis;
                    end
                    if (swap) begin
                        active_x[gi]   <= shadow_x[gi];
                        active_y[gi]   <= shadow_y[gi];
                        active_vis[gi] <= shadow_vis[gi];
                    end
                end
            end
        end
    endgenerate

    // Commit FSM: IDLE accepts writes and commits, PENDING waits for vblank.
    // A frame_start in the commit cycle itself is seen while still IDLE, so
    // the swap always lands on a strictly later frame.
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            state_reg      <= IDLE;
            commit_pending <= 1'b0;
            swap_done      <= 1'b0;
            frame_count    <= '0;
        end else begin
            swap_done <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (commit) begin
                        state_reg      <= PENDING;
                        commit_pending <= 1'b1;
                    end
                end
                PENDING: begin
                    if (frame_start) begin
                        state_reg      <= IDLE;
                        commit_pending <= 1'b0;
                        swap_done      <= 1'b1;
                        frame_count    <= frame_count + CNT_W'(1);
                    end
                end
                default: begin
                    state_reg      <= IDLE;
                    commit_pending <= 1'b0;
                end
            endcase
        end
    end

    // Sticky write-error flag; a new error in the clear cycle wins.
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            wr_err <= 1'b0;
        end else if (wr_reject) begin
            wr_err <= 1'b1;
        end else if (err_clr) begin
            wr_err <= 1'b0;
        end
    end

    // Registered read of the active bank; data holds when no read is issued.
    // Reading on the swap edge sees the pre-swap contents.
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            rd_x     <= '0;
            rd_y     <= '0;
            rd_vis   <= 1'b0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) begin
                if (rd_in_range) begin
                    rd_x   <= active_x[rd_index];
                    rd_y   <= active_y[rd_index];
                    rd_vis <= active_vis[rd_index];
                end else begin
                    rd_x   <= '0;
                    rd_y   <= '0;
                    rd_vis <= 1'b0;
                end
            end
        end
    end

endmodule

// File: doc/ball_state_bank.md
Name: ball_state_bank

Overview:
- Double-buffered position/visibility store for up to NUM_BALLS objects: the 15 numbered balls, the cue ball and the pool cue.
- Software writes a shadow bank through a simple write port, then requests a commit.
- The shadow bank is copied into the active bank only at the next video frame boundary, so the renderer never sees a torn table state.
- The renderer reads the active bank by index. A one-cycle completion pulse is returned to the processor as its hardware signal.

Parameters:
- NUM_BALLS, 17: number of object slots. Must be ≤ 2**IDX_W.
- IDX_W, 5: width of slot index buses.
- X_W, 10: x coordinate width, unsigned pixels.
- Y_W, 10: y coordinate width, unsigned pixels.
- CNT_W, 16: width of the committed-frame counter.

Ports:
- clk_clk  in  1  system clock; all logic is on the rising edge.
- reset_reset  in  1  asynchronous, active-high reset.
- wr_en  in  1  write strobe into the shadow bank.
- wr_index  in  IDX_W  slot to write.
- wr_x  in  X_W  x position.
- wr_y  in  Y_W  y position.
- wr_vis  in  1  1 = on table, 0 = pocketed/hidden.
- commit  in  1  request a shadow→active copy at the next frame boundary.
- frame_start  in  1  single-cycle pulse from the VGA controller at vblank start.
- err_clr  in  1  clears wr_err.
- rd_en  in  1  renderer read strobe.
- rd_index  in  IDX_W  slot to read from the active bank.
- rd_x  out  X_W  active x.
- rd_y  out  Y_W  active y.
- rd_vis  out  1  active visibility.
- rd_valid  out  1  rd_* outputs valid.
- commit_pending  out  1  commit accepted, swap not yet done.
- swap_done  out  1  one-cycle pulse on the swap edge.
- frame_count  out  CNT_W  number of swaps completed.
- wr_err  out  1  sticky error flag.

Behaviour:
- Reset (asynchronous, active-high):
  - all shadow and active slots cleared to x=0, y=0, vis=0;
  - state IDLE;
  - rd_x/rd_y/rd_vis/rd_valid = 0;
  - commit_pending = 0, swap_done = 0, frame_count = 0, wr_err = 0.
  - Reset mid-commit abandons the commit; no swap occurs.
- State IDLE:
  - wr_en with wr_index < NUM_BALLS updates that shadow slot at the clock edge.
  - wr_en with wr_index ≥ NUM_BALLS is dropped and sets wr_err.
  - commit → PENDING and commit_pending = 1 from the next cycle.
  - wr_en and commit in the same cycle: the write is accepted and the commit is taken.
  - frame_start in IDLE has no effect.
- State PENDING:
  - Writes are dropped and set wr_err; the shadow bank is frozen.
  - commit is ignored.
  - frame_start causes the full shadow bank to be copied into the active bank in parallel at that edge. At the same edge:
    - state → IDLE;
    - commit_pending → 0;
    - swap_done = 1 for exactly one cycle;
    - frame_count increments, wrapping from all-ones to 0.
- A commit and a frame_start in the same cycle do not swap on that frame. The swap happens at the next frame_start strictly after the commit cycle.
- wr_err:
  - err_clr clears it.
  - If a new error occurs in the same cycle as err_clr, wr_err remains 1 (set wins).
- Read path:
  - Registered, 1-cycle latency: rd_en sampled at edge N gives rd_valid = 1 and data during cycle N+1.
  - rd_valid = 0 when rd_en was 0; rd_x/rd_y/rd_vis hold their last values.
  - rd_index ≥ NUM_BALLS returns zeros with rd_valid = 1.
  - A read sampled on the swap edge returns pre-swap active data. Reads sampled on the next edge return new data.
  - Back-to-back reads are supported every cycle.
- The shadow bank persists after a swap. Software rewrites only the slots that changed.

Test Plan:
- Reset then read slots 0..16 → rd_valid=1 one cycle after each rd_en; x=0, y=0, vis=0 for all.
- Write slot 3 (x=412, y=233, vis=1), commit, read slot 3 before frame_start → old zeros. Pulse frame_start → swap_done pulses one cycle; frame_count=1; next read gives 412/233/1.
- Commit and frame_start in the same cycle → no swap, commit_pending=1. Second frame_start → swap, frame_count increments by exactly 1.
- Write slot 5 while PENDING → write dropped, wr_err=1, slot 5 unchanged after the swap. err_clr → wr_err=0. wr_index=20 with err_clr in the same cycle → wr_err stays 1.
- Read slot 7 sampled on the swap edge → old value; read on the following edge → new value. rd_index=31 → zeros with valid.
- Assert reset while PENDING → commit_pending=0 immediately, active bank all zeros. A later frame_start produces no swap_done.
- Force frame_count to 0xFFFF (or run 65536 commit/frame pairs) → next swap wraps it to 0.
